mux_select_sequencer: RTL and testbench

//  Upstream stage of the fixed/variable 4-bit mux. Assembles the 6-bit selector from a serial
//  bit stream and drives it onto the mux select bus only as a complete, atomically committed code.

---
 rtl/mux_seq_pkg.sv | 17 +
 rtl/mux_select_sequencer_shifter.sv | 42 ++++
 rtl/mux_select_sequencer.sv | 138 +++++++++++++
 tb/tb_mux_select_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the mux selector sequencer slice.
// No logic; state encoding, default widths and named selector codes.
package mux_seq_pkg;

  localparam int SEL_W_DEF  = 6;
  localparam int DATA_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ARMED = 2'd2
  } seq_state_t;

  localparam logic [SEL_W_DEF-1:0] SEL_ALL_ONES = '1;
  localparam logic [SEL_W_DEF-1:0] SEL_NONE     = '0;

endpackage

// File: rtl/mux_select_sequencer_shifter.sv
// Serial-to-parallel selector assembly: shift register plus bit counter, MSB first.
// code/done are combinational for the current bit so the commit lands on the same edge; no backpressure.
module serial_code_shifter
  import mux_seq_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             bit_in,
  output logic [SEL_W-1:0] code,
  output logic             done
);

  localparam int CW = $clog2(SEL_W + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(SEL_W - 1);

  logic [SEL_W-1:0] shreg;
  logic [SEL_W-1:0] shreg_d;
  logic [CW-1:0]    bit_cnt;

  assign shreg_d = shift_en ? {shreg[SEL_W-2:0], bit_in} : shreg;
  // code is the value the register takes on this edge, i.e. the completed code when done is high
  assign code    = shreg_d;
  assign done    = shift_en && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      shreg <= shreg_d;
      if (shift_en) bit_cnt <= done ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mux_select_sequencer.sv
// Builds the mux selector serially and commits it atomically; c_out valid right after the last bit's edge.
// Backpressure: sel_ready drops while a code is held (ARMED); data_in loads independently of the FSM.
module mux_select_sequencer
  import mux_seq_pkg::*;
#(
  parameter int SEL_W       = SEL_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int HOLD_CYCLES = 16,
  parameter int TIMEOUT     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_load,
  input  logic              sel_bit,
  input  logic              sel_valid,
  output logic              sel_ready,
  input  logic              sel_clear,
  output logic [DATA_W-1:0] a_out,
  output logic [SEL_W-1:0]  c_out,
  output logic              armed,
  output logic              err_timeout
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  seq_state_t       state, state_n;
  logic [SEL_W-1:0] c_n;
  logic             armed_n, err_n;
  logic [IW-1:0]    idle_cnt, idle_n;
  logic [HW-1:0]    hold_cnt, hold_n;
  logic             shift_en, shift_clr, xfer;
  logic [SEL_W-1:0] code;
  logic             done;

  assign sel_ready = (state != ARMED);
  assign xfer      = sel_valid && sel_ready;

  serial_code_shifter #(.SEL_W(SEL_W)) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .clr      (shift_clr),
    .bit_in   (sel_bit),
    .code     (code),
    .done     (done)
  );

  always_comb begin
    state_n   = state;
    c_n       = c_out;
    armed_n   = armed;
    err_n     = 1'b0;
    idle_n    = idle_cnt;
    hold_n    = hold_cnt;
    shift_en  = 1'b0;
    shift_clr = 1'b0;
    if (sel_clear) begin
      state_n   = IDLE;
      c_n       = '0;
      armed_n   = 1'b0;
      idle_n    = '0;
      hold_n    = '0;
      shift_clr = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          idle_n = '0;
          hold_n = '0;
          if (xfer) begin
            shift_en = 1'b1;
            state_n  = SHIFT;
          end
        end
        SHIFT: begin
          if (xfer) begin
            shift_en = 1'b1;
            idle_n   = '0;
            if (done) begin
              c_n     = code;
              armed_n = 1'b1;
              hold_n  = '0;
              state_n = ARMED;
            end
          end else if (idle_cnt == IDLE_LAST) begin
            // abandon the partial code; c_out keeps whatever was last committed
            shift_clr = 1'b1;
            err_n     = 1'b1;
            idle_n    = '0;
            state_n   = IDLE;
          end else begin
            idle_n = idle_cnt + 1'b1;
          end
        end
        ARMED: begin
          if (HOLD_CYCLES > 0) begin
            if (hold_cnt == HOLD_LAST) begin
              c_n     = '0;
              armed_n = 1'b0;
              hold_n  = '0;
              state_n = IDLE;
            end else begin
              hold_n = hold_cnt + 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      c_out       <= '0;
      armed       <= 1'b0;
      err_timeout <= 1'b0;
      idle_cnt    <= '0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_n;
      c_out       <= c_n;
      armed       <= armed_n;
      err_timeout <= err_n;
      idle_cnt    <= idle_n;
      hold_cnt    <= hold_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         a_out <= '0;
    else if (data_load) a_out <= data_in;
  end

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Directed bench for mux_select_sequencer: every expected c_out change is queued before its
// stimulus and checked by a monitor; cycle-exact points are checked inline.
module tb_mux_select_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] data_in;
  logic       data_load;
  logic       sel_bit;
  logic       sel_valid;
  logic       sel_ready;
  logic       sel_clear;
  logic [3:0] a_out;
  logic [5:0] c_out;
  logic       armed;
  logic       err_timeout;

  int n_cmp = 0;
  int n_err = 0;
  logic [5:0] exp_q[$];
  logic [5:0] prev_c = '0;

  mux_select_sequencer #(
    .SEL_W(6), .DATA_W(4), .HOLD_CYCLES(16), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_load(data_load),
    .sel_bit(sel_bit), .sel_valid(sel_valid), .sel_ready(sel_ready),
    .sel_clear(sel_clear), .a_out(a_out), .c_out(c_out), .armed(armed),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // every change of c_out must match the next queued expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && c_out !== prev_c) begin
      if (exp_q.size() == 0) chk("c_out_unexpected_change", {26'd0, c_out}, {26'd0, prev_c});
      else chk("c_out_scoreboard", {26'd0, c_out}, {26'd0, exp_q.pop_front()});
    end
    prev_c = c_out;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sel_valid = 1'b1;
    sel_bit   = b;
    step();
    sel_valid = 1'b0;
    sel_bit   = 1'b0;
  endtask

  task automatic send_code(input logic [5:0] code);
    for (int i = 5; i >= 0; i--) send_bit(code[i]);
  endtask

  task automatic do_clear();
    sel_clear = 1'b1;
    step();
    sel_clear = 1'b0;
  endtask

  initial begin
    int errs;
    int err_at;
    logic [5:0] pat;
    rst_n = 1'b0; data_in = '0; data_load = 1'b0;
    sel_bit = 1'b0; sel_valid = 1'b0; sel_clear = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_c_out", {26'd0, c_out}, 32'd0);
    chk("rst_armed", {31'd0, armed}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    chk("rst_a_out", {28'd0, a_out}, 32'd0);
    chk("rst_sel_ready", {31'd0, sel_ready}, 32'd1);

    // reset mid-shift after 3 bits discards the partial code
    data_in = 4'h5; data_load = 1'b1;
    send_bit(1'b1);
    data_load = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a_out", {28'd0, a_out}, 32'd0);
    chk("async_rst_c_out", {26'd0, c_out}, 32'd0);
    chk("async_rst_armed", {31'd0, armed}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_sel_ready", {31'd0, sel_ready}, 32'd1);
    exp_q.push_back(6'b000111);
    send_code(6'b000111);
    chk("post_rst_commit_armed", {31'd0, armed}, 32'd1);
    exp_q.push_back(6'b000000);
    do_clear();

    // commit all-ones, then auto-clear after 16 cycles
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("no_partial_c_out", {26'd0, c_out}, 32'd0);
    chk("no_partial_armed", {31'd0, armed}, 32'd0);
    exp_q.push_back(6'b111111);
    send_bit(1'b1);
    chk("commit_c_out", {26'd0, c_out}, 32'h3F);
    chk("commit_armed", {31'd0, armed}, 32'd1);
    chk("commit_sel_ready", {31'd0, sel_ready}, 32'd0);
    repeat (15) step();
    chk("hold_armed_last", {31'd0, armed}, 32'd1);
    exp_q.push_back(6'b000000);
    step();
    chk("autoclear_armed", {31'd0, armed}, 32'd0);
    chk("autoclear_c_out", {26'd0, c_out}, 32'd0);

    // timeout after 3 bits and 8 idle cycles
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    errs = 0; err_at = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (err_timeout) begin errs++; err_at = i; end
    end
    chk("timeout_pulses", errs, 32'd1);
    chk("timeout_cycle", err_at, 32'd8);
    chk("timeout_c_out", {26'd0, c_out}, 32'd0);
    chk("timeout_sel_ready", {31'd0, sel_ready}, 32'd1);
    exp_q.push_back(6'b101010);
    send_code(6'b101010);
    chk("after_timeout_armed", {31'd0, armed}, 32'd1);
    exp_q.push_back(6'b000000);
    do_clear();

    // sel_clear with the 6th bit wins: no commit
    pat = 6'b110011;
    for (int i = 5; i >= 1; i--) send_bit(pat[i]);
    sel_clear = 1'b1;
    send_bit(pat[0]);
    sel_clear = 1'b0;
    chk("clear_prio_c_out", {26'd0, c_out}, 32'd0);
    chk("clear_prio_armed", {31'd0, armed}, 32'd0);
    chk("clear_prio_sel_ready", {31'd0, sel_ready}, 32'd1);
    exp_q.push_back(6'b010110);
    send_code(6'b010110);

    // backpressure while armed: bits are ignored and c_out holds
    for (int i = 0; i < 5; i++) begin
      sel_valid = 1'b1; sel_bit = i[0];
      #1;
      chk("bp_sel_ready", {31'd0, sel_ready}, 32'd0);
      step();
    end
    sel_valid = 1'b0;
    chk("bp_c_out_held", {26'd0, c_out}, 32'h16);
    exp_q.push_back(6'b000000);
    do_clear();

    // data load during SHIFT does not disturb the FSM
    send_bit(1'b1); send_bit(1'b1);
    data_in = 4'hA; data_load = 1'b1;
    send_bit(1'b0);
    data_load = 1'b0;
    chk("data_load_a_out", {28'd0, a_out}, 32'hA);
    chk("data_load_sel_ready", {31'd0, sel_ready}, 32'd1);
    exp_q.push_back(6'b110011);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    chk("data_commit_armed", {31'd0, armed}, 32'd1);
    exp_q.push_back(6'b000000);
    repeat (17) step();
    chk("data_a_out_kept", {28'd0, a_out}, 32'hA);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
